ethernet_receiver: RTL and testbench
====================================

ETHERNET_RECEIVER -- requirements
Module: ethernet_receiver

Interface
REQ-001 SHALL have parameter data_width_p, default 32, AXIS/host data width in bits; only 32 and 64 are legal.
REQ-002 SHALL have parameter eth_mtu_p, default 2048, maximum packet size in bytes per slot.
REQ-003 SHALL have parameter recv_count_p, default 65535, saturation value of both packet counters.
REQ-004 SHALL have a single clock and a synchronous, active-high reset:
- clk_i  in  1  sole clock; all state updates on posedge.
- reset_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have the AXIS receive ports:
- rx_axis_tdata_i  in  data_width_p  beat data, byte lane 0 = lowest packet byte.
- rx_axis_tkeep_i  in  data_width_p/8  valid byte lanes; contiguous from lane 0.
- rx_axis_tvalid_i  in  1  beat valid.
- rx_axis_tlast_i  in  1  final beat of packet.
- rx_axis_tuser_i  in  1  bad-frame flag; sampled on tlast beat only.
- rx_axis_tready_o  out  1  beat accepted when tvalid & tready.
REQ-006 SHALL have the host read ports:
- packet_avail_o  out  1  at least one committed packet.
- packet_ack_i  in  1  release oldest committed packet.
- packet_rvalid_i  in  1  read request.
- packet_raddr_i  in  $clog2(eth_mtu_p)  byte address in oldest packet; low $clog2(data_width_p/8) bits ignored.
- packet_rdata_o  out  data_width_p  read data.
- packet_rsize_o  out  $clog2(eth_mtu_p+1)  byte size of oldest packet.
REQ-007 SHALL have the status ports:
- recv_count_o  out  $clog2(recv_count_p+1)  packets committed.
- drop_count_o  out  $clog2(recv_count_p+1)  packets dropped.

Function
REQ-008 SHALL buffer two packet slots of eth_mtu_p bytes each, filled and drained in FIFO order.
REQ-009 SHALL implement states RECV, DISCARD, FULL; reset state RECV, or FULL if no free slot.
REQ-010 In RECV, rx_axis_tready_o SHALL be 1; each accepted beat SHALL be written at word index wptr, then wptr+1; byte count SHALL add popcount(tkeep).
REQ-011 On an accepted tlast beat with tuser=0 and byte count ≤ eth_mtu_p, the slot SHALL commit with its byte count; packet_avail_o=1 next cycle; recv_count_o +1.
REQ-012 On an accepted tlast beat with tuser=1, or a zero-byte packet, the slot SHALL not commit; wptr and byte count SHALL clear; drop_count_o +1.
REQ-013 An accepted non-tlast beat at wptr = eth_mtu_p/(data_width_p/8)-1 SHALL enter DISCARD; the beat arriving after the final word is not written.
REQ-014 In DISCARD, tready_o SHALL be 1; beats SHALL be discarded; tlast SHALL clear wptr and byte count, increment drop_count_o and return to RECV or FULL.
REQ-015 With both slots committed, the FSM SHALL be in FULL and tready_o SHALL be 0; tready_o SHALL return to 1 the cycle after packet_ack_i frees a slot.
REQ-016 packet_rdata_o SHALL present the word at packet_raddr_i of the oldest packet one cycle after packet_rvalid_i and hold it until the next read.
REQ-017 packet_ack_i SHALL be ignored when packet_avail_o=0; simultaneous commit and ack SHALL both take effect, leaving one packet committed.
REQ-018 Counters SHALL saturate at recv_count_p.
REQ-019 Simulation-only assertions SHALL flag: non-contiguous tkeep; zero tkeep on a non-tlast beat; unsupported data_width_p.

Reset
REQ-020 In reset: tready_o=0, packet_avail_o=0, packet_rsize_o=0, packet_rdata_o=0, counters 0, both slots empty, wptr 0, state RECV; tready_o=1 on the first cycle after reset deasserts.
REQ-021 Reset mid-packet SHALL discard the partial packet without incrementing drop_count_o.

Verification
REQ-022 32-bit, 10-byte packet, tkeep 1111,1111,0011 -> avail=1 the cycle after tlast; rsize=10; raddr 0/4/8 return beats 0/1/2; recv_count=1.
REQ-023 Two packets, no ack -> tready_o=0 after the second tlast; one ack -> tready_o=1 next cycle; third packet commits.
REQ-024 tuser=1 on tlast -> avail stays 0; drop_count=1; next 4-byte packet reads at raddr 0, rsize=4.
REQ-025 eth_mtu_p=2048, 32-bit, 513-beat packet -> DISCARD; tready_o stays 1 through tlast; drop_count=1; avail=0.
REQ-026 Reset after 5 beats -> all outputs at reset values; following 8-byte packet gives rsize=8, recv_count=1.
REQ-027 Ack in the same cycle as a commit with one packet held -> avail stays 1; rsize switches to the new packet size.

Source files
------------

// File: rtl/ethernet_receiver_if.sv
// AXI-Stream receive bundle for the Ethernet receiver.
// master drives beats (tdata/tkeep/tvalid/tlast/tuser); slave returns tready.
interface ethernet_receiver_if #(
  parameter int data_width_p = 32
);
  logic [data_width_p-1:0]   rx_axis_tdata_i;
  logic [data_width_p/8-1:0] rx_axis_tkeep_i;
  logic                      rx_axis_tvalid_i;
  logic                      rx_axis_tlast_i;
  logic                      rx_axis_tuser_i;
  logic                      rx_axis_tready_o;

  modport master (
    output rx_axis_tdata_i,
    output rx_axis_tkeep_i,
    output rx_axis_tvalid_i,
    output rx_axis_tlast_i,
    output rx_axis_tuser_i,
    input  rx_axis_tready_o
  );

  modport slave (
    input  rx_axis_tdata_i,
    input  rx_axis_tkeep_i,
    input  rx_axis_tvalid_i,
    input  rx_axis_tlast_i,
    input  rx_axis_tuser_i,
    output rx_axis_tready_o
  );
endinterface

// File: rtl/ethernet_receiver.sv
// Two-slot Ethernet packet receiver: AXIS in, random-access host reads out.
// Ports: clk_i/reset_i, rx_if (AXIS slave), packet_* host read, recv/drop counts.
module ethernet_receiver #(
  parameter int data_width_p = 32,
  parameter int eth_mtu_p    = 2048,
  parameter int recv_count_p = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  ethernet_receiver_if.slave rx_if,
  output logic packet_avail_o,
  input  logic packet_ack_i,
  input  logic packet_rvalid_i,
  input  logic [$clog2(eth_mtu_p)-1:0] packet_raddr_i,
  output logic [data_width_p-1:0] packet_rdata_o,
  output logic [$clog2(eth_mtu_p+1)-1:0] packet_rsize_o,
  output logic [$clog2(recv_count_p+1)-1:0] recv_count_o,
  output logic [$clog2(recv_count_p+1)-1:0] drop_count_o
);
  localparam int bytes_lp = data_width_p / 8;
  localparam int words_lp = eth_mtu_p / bytes_lp;
  localparam int wb_lp = $clog2(words_lp);
  localparam int ab_lp = $clog2(eth_mtu_p);
  localparam int ob_lp = $clog2(bytes_lp);
  localparam int sb_lp = $clog2(eth_mtu_p + 1);
  localparam int cb_lp = $clog2(recv_count_p + 1);

  typedef enum logic [1:0] {
    RECV,
    DISCARD,
    FULL
  } state_e;

  state_e state_q, state_d;
  logic [wb_lp-1:0] wptr_q, wptr_d;
  logic [sb_lp-1:0] bcnt_q, bcnt_d, bsum;
  logic [sb_lp-1:0] size_q [2];
  logic [sb_lp-1:0] size_d [2];
  logic [1:0] held_q, held_d;
  logic wslot_q, wslot_d;
  logic rslot_q, rslot_d;
  logic [cb_lp-1:0] recv_q, recv_d;
  logic [cb_lp-1:0] drop_q, drop_d;
  logic [data_width_p-1:0] mem [2*words_lp];
  logic [data_width_p-1:0] rdata_q;
  logic tready, beat, last_word;
  logic commit, drop, ack, wr_en;
  logic unused_raddr;

  function automatic logic [sb_lp-1:0] popcnt(
    input logic [bytes_lp-1:0] k
  );
    popcnt = '0;
    for (int i = 0; i < bytes_lp; i++)
      popcnt = popcnt + sb_lp'(k[i]);
  endfunction

  assign tready = ~reset_i & (state_q != FULL);
  assign rx_if.rx_axis_tready_o = tready;
  assign beat = rx_if.rx_axis_tvalid_i & tready;
  assign bsum = bcnt_q + popcnt(rx_if.rx_axis_tkeep_i);
  assign last_word = (wptr_q == wb_lp'(words_lp - 1));
  assign ack = packet_ack_i & (held_q != 2'd0);
  assign unused_raddr = ^packet_raddr_i[ob_lp-1:0];

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    bcnt_d  = bcnt_q;
    size_d  = size_q;
    held_d  = held_q;
    wslot_d = wslot_q;
    rslot_d = rslot_q;
    recv_d  = recv_q;
    drop_d  = drop_q;
    commit  = 1'b0;
    drop    = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      RECV: begin
        if (beat) begin
          wr_en = 1'b1;
          if (rx_if.rx_axis_tlast_i) begin
            wptr_d = '0;
            bcnt_d = '0;
            if (!rx_if.rx_axis_tuser_i && bsum != '0 &&
                bsum <= sb_lp'(eth_mtu_p))
              commit = 1'b1;
            else
              drop = 1'b1;
          end else if (last_word) begin
            // slot is full and more data follows: give up on it
            state_d = DISCARD;
            wptr_d  = '0;
            bcnt_d  = '0;
          end else begin
            wptr_d = wptr_q + wb_lp'(1);
            bcnt_d = bsum;
          end
        end
      end
      DISCARD: begin
        if (beat && rx_if.rx_axis_tlast_i) begin
          drop    = 1'b1;
          wptr_d  = '0;
          bcnt_d  = '0;
          state_d = RECV;
        end
      end
      FULL: begin
      end
      default: state_d = RECV;
    endcase

    if (commit) begin
      size_d[wslot_q] = bsum;
      wslot_d = ~wslot_q;
      if (recv_q != cb_lp'(recv_count_p))
        recv_d = recv_q + cb_lp'(1);
    end
    if (drop && drop_q != cb_lp'(recv_count_p))
      drop_d = drop_q + cb_lp'(1);
    if (ack)
      rslot_d = ~rslot_q;

    if (commit && !ack)
      held_d = held_q + 2'd1;
    else if (!commit && ack)
      held_d = held_q - 2'd1;

    // slot occupancy decides between accepting and back-pressuring
    if (state_d != DISCARD)
      state_d = (held_d == 2'd2) ? FULL : RECV;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RECV;
      wptr_q    <= '0;
      bcnt_q    <= '0;
      size_q[0] <= '0;
      size_q[1] <= '0;
      held_q    <= '0;
      wslot_q   <= 1'b0;
      rslot_q   <= 1'b0;
      recv_q    <= '0;
      drop_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      size_q  <= size_d;
      held_q  <= held_d;
      wslot_q <= wslot_d;
      rslot_q <= rslot_d;
      recv_q  <= recv_d;
      drop_q  <= drop_d;
      if (packet_rvalid_i)
        rdata_q <= mem[{rslot_q, packet_raddr_i[ab_lp-1:ob_lp]}];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[{wslot_q, wptr_q}] <= rx_if.rx_axis_tdata_i;
  end

  assign packet_avail_o = (held_q != 2'd0);
  assign packet_rsize_o = packet_avail_o ? size_q[rslot_q] : '0;
  assign packet_rdata_o = rdata_q;
  assign recv_count_o   = recv_q;
  assign drop_count_o   = drop_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (data_width_p == 32 || data_width_p == 64)
        else $error("unsupported data_width_p");
      if (beat) begin
        assert ((rx_if.rx_axis_tkeep_i &
                 (rx_if.rx_axis_tkeep_i + bytes_lp'(1))) == '0)
          else $error("non-contiguous tkeep");
        assert (rx_if.rx_axis_tlast_i || rx_if.rx_axis_tkeep_i != '0)
          else $error("zero tkeep on non-last beat");
      end
    end
  end
`endif
endmodule

// File: tb/tb_ethernet_receiver.sv
// Bench for ethernet_receiver: directed packets, read scoreboard.
// Reads push expected words; a negedge monitor pops and compares.
module tb_ethernet_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic packet_avail, packet_ack, packet_rvalid;
  logic [10:0] packet_raddr;
  logic [31:0] packet_rdata;
  logic [11:0] packet_rsize;
  logic [15:0] recv_count, drop_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q [$];
  logic rd_pend = 1'b0;

  ethernet_receiver_if #(.data_width_p(32)) rx_if ();

  ethernet_receiver #(
    .data_width_p(32),
    .eth_mtu_p(2048),
    .recv_count_p(65535)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .rx_if(rx_if),
    .packet_avail_o(packet_avail),
    .packet_ack_i(packet_ack),
    .packet_rvalid_i(packet_rvalid),
    .packet_raddr_i(packet_raddr),
    .packet_rdata_o(packet_rdata),
    .packet_rsize_o(packet_rsize),
    .recv_count_o(recv_count),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pat(input int s, input int i);
    return {8'(s), 8'hC3, 16'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rd_pend <= packet_rvalid;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected none", packet_rdata);
      end else begin
        chk("rdata", {32'h0, packet_rdata}, {32'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic rd(input int addr, input logic [31:0] exp);
    packet_rvalid = 1'b1;
    packet_raddr = 11'(addr);
    sb_q.push_back(exp);
    step();
    packet_rvalid = 1'b0;
  endtask

  task automatic ack();
    packet_ack = 1'b1;
    step();
    packet_ack = 1'b0;
  endtask

  task automatic send(input int nbytes, input bit bad, input int s,
                      input int stop_at, input bit ack_last,
                      output int stalls);
    int nb;
    nb = (nbytes + 3) / 4;
    if (nb == 0) nb = 1;
    stalls = 0;
    for (int i = 0; i < nb; i++) begin
      int rem;
      int wc;
      bit ok;
      bit last;
      if (stop_at > 0 && i == stop_at) break;
      rem = nbytes - 4 * i;
      last = (i == nb - 1) && (stop_at == 0);
      rx_if.rx_axis_tdata_i = pat(s, i);
      rx_if.rx_axis_tkeep_i = (rem >= 4) ? 4'hF : 4'(4'hF >> (4 - rem));
      rx_if.rx_axis_tvalid_i = 1'b1;
      rx_if.rx_axis_tlast_i = last;
      rx_if.rx_axis_tuser_i = bad && last;
      if (ack_last && last) packet_ack = 1'b1;
      wc = 0;
      ok = 1'b0;
      while (!ok) begin
        @(negedge clk);
        ok = rx_if.rx_axis_tready_o;
        if (!ok) stalls++;
        step();
        wc++;
        if (!ok && wc > 2000) begin
          tests++;
          fails++;
          $display("FAIL send_timeout: got tready 0 expected 1");
          $fatal(1, "send stalled");
        end
      end
    end
    rx_if.rx_axis_tvalid_i = 1'b0;
    rx_if.rx_axis_tlast_i = 1'b0;
    rx_if.rx_axis_tuser_i = 1'b0;
    packet_ack = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tready", 64'(rx_if.rx_axis_tready_o), 64'd0);
    chk("rst_avail", 64'(packet_avail), 64'd0);
    chk("rst_rsize", 64'(packet_rsize), 64'd0);
    chk("rst_rdata", 64'(packet_rdata), 64'd0);
    chk("rst_recv", 64'(recv_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
  endtask

  initial begin
    int st;
    rx_if.rx_axis_tdata_i = '0;
    rx_if.rx_axis_tkeep_i = '0;
    rx_if.rx_axis_tvalid_i = 1'b0;
    rx_if.rx_axis_tlast_i = 1'b0;
    rx_if.rx_axis_tuser_i = 1'b0;
    packet_ack = 1'b0;
    packet_rvalid = 1'b0;
    packet_raddr = '0;
    repeat (3) step();
    chk_reset_outputs();
    reset = 1'b0;
    #1;
    chk("tready_after_rst", 64'(rx_if.rx_axis_tready_o), 64'd1);

    // 10-byte packet: keep 1111,1111,0011
    send(10, 0, 1, 0, 0, st);
    chk("t1_avail", 64'(packet_avail), 64'd1);
    chk("t1_rsize", 64'(packet_rsize), 64'd10);
    chk("t1_recv", 64'(recv_count), 64'd1);
    rd(0, pat(1, 0));
    rd(4, pat(1, 1));
    rd(8, pat(1, 2));
    rd(5, pat(1, 1));
    repeat (3) step();
    chk("t1_hold", 64'(packet_rdata), 64'(pat(1, 1)));
    ack();
    chk("t1_avail_ack", 64'(packet_avail), 64'd0);
    chk("t1_rsize_ack", 64'(packet_rsize), 64'd0);

    // two packets fill both slots
    send(8, 0, 2, 0, 0, st);
    send(12, 0, 3, 0, 0, st);
    chk("t2_full_tready", 64'(rx_if.rx_axis_tready_o), 64'd0);
    chk("t2_rsize_a", 64'(packet_rsize), 64'd8);
    rd(0, pat(2, 0));
    ack();
    chk("t2_tready_ack", 64'(rx_if.rx_axis_tready_o), 64'd1);
    chk("t2_rsize_b", 64'(packet_rsize), 64'd12);
    rd(4, pat(3, 1));
    send(4, 0, 4, 0, 0, st);
    chk("t2_recv", 64'(recv_count), 64'd4);
    chk("t2_full2", 64'(rx_if.rx_axis_tready_o), 64'd0);
    ack();
    chk("t2_rsize_c", 64'(packet_rsize), 64'd4);
    rd(0, pat(4, 0));
    ack();
    chk("t2_empty", 64'(packet_avail), 64'd0);
    ack();
    chk("t2_ack_ignored", 64'(packet_avail), 64'd0);

    // bad frame, then zero-byte frame, then good 4-byte frame
    send(8, 1, 5, 0, 0, st);
    chk("t3_bad_avail", 64'(packet_avail), 64'd0);
    chk("t3_bad_drop", 64'(drop_count), 64'd1);
    send(0, 0, 6, 0, 0, st);
    chk("t3_zero_drop", 64'(drop_count), 64'd2);
    chk("t3_zero_avail", 64'(packet_avail), 64'd0);
    send(4, 0, 6, 0, 0, st);
    chk("t3_rsize", 64'(packet_rsize), 64'd4);
    chk("t3_recv", 64'(recv_count), 64'd5);
    rd(0, pat(6, 0));
    ack();

    // 513 beats overflow the slot; 512 beats fit exactly
    send(2052, 0, 7, 0, 0, st);
    chk("t4_stalls", 64'(st), 64'd0);
    chk("t4_drop", 64'(drop_count), 64'd3);
    chk("t4_avail", 64'(packet_avail), 64'd0);
    send(2048, 0, 8, 0, 0, st);
    chk("t4_mtu_rsize", 64'(packet_rsize), 64'd2048);
    chk("t4_mtu_recv", 64'(recv_count), 64'd6);
    rd(2044, pat(8, 511));
    rd(0, pat(8, 0));
    ack();

    // ack coincident with commit while one packet is held
    send(4, 0, 9, 0, 0, st);
    chk("t5_rsize_d", 64'(packet_rsize), 64'd4);
    send(8, 0, 10, 0, 1, st);
    chk("t5_avail", 64'(packet_avail), 64'd1);
    chk("t5_rsize_e", 64'(packet_rsize), 64'd8);
    chk("t5_recv", 64'(recv_count), 64'd8);
    rd(4, pat(10, 1));
    ack();
    chk("t5_empty", 64'(packet_avail), 64'd0);

    // reset mid-packet after 5 beats
    send(40, 0, 11, 5, 0, st);
    reset = 1'b1;
    step();
    chk_reset_outputs();
    reset = 1'b0;
    #1;
    chk("t6_tready", 64'(rx_if.rx_axis_tready_o), 64'd1);
    send(8, 0, 12, 0, 0, st);
    chk("t6_rsize", 64'(packet_rsize), 64'd8);
    chk("t6_recv", 64'(recv_count), 64'd1);
    chk("t6_drop", 64'(drop_count), 64'd0);
    rd(4, pat(12, 1));
    repeat (3) step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
